regfile_sb: RTL

Parametrised MIPS general-purpose register file with N combinational read ports, one writeback port and a per-register pending-write scoreboard. It sits between decode/issue and writeback. Issue marks destination registers pending, writeback clears them, and read ports report whether their source is still pending so decode can stall. Register 0 is hardwired to zero. Optional same-cycle write-to-read bypass is compiled in by macro.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_rdport.sv | 36 +++
 rtl/regfile_sb.sv | 75 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the regfile_sb register file
package regfile_pkg;
  localparam int REG_ZERO    = 0;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_REGBITS = 5;
  typedef logic [DEF_REGBITS-1:0] reg_addr_t;
  typedef logic [DEF_WIDTH-1:0]   reg_data_t;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one read port (zero masking, optional bypass, busy flag); bypass under REGFILE_BYPASS_EN
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int REGBITS = DEF_REGBITS
) (
  input  logic [REGBITS-1:0] ra_i,
  input  logic [WIDTH-1:0]   ram_rd_i,
  input  logic               pend_i,
  input  logic               regwrite_i,
  input  logic [REGBITS-1:0] wa_i,
  input  logic [WIDTH-1:0]   wd_i,
  output logic [WIDTH-1:0]   rd_o,
  output logic               rbusy_o
);
  logic zero;
  assign zero = ra_i == REGBITS'(REG_ZERO);
`ifdef REGFILE_BYPASS_EN
  logic hit;
  assign hit = regwrite_i && (wa_i == ra_i) && !zero;
  // forward same-cycle writeback data and mask the busy flag it is about to clear
  always_comb begin
    rd_o    = zero ? '0 : (hit ? wd_i : ram_rd_i);
    rbusy_o = !zero && pend_i && !hit;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{regwrite_i, wa_i, wd_i};
  // stored contents and registered pending state only
  always_comb begin
    rd_o    = zero ? '0 : ram_rd_i;
    rbusy_o = !zero && pend_i;
  end
`endif
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: MIPS register file with pending-write scoreboard; REGFILE_BYPASS_EN enables write-to-read bypass
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int REGBITS = DEF_REGBITS,
  parameter int NREAD   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREAD*REGBITS-1:0] ra,
  output logic [NREAD*WIDTH-1:0]   rd,
  output logic [NREAD-1:0]         rbusy,
  input  logic                     iss_valid,
  input  logic [REGBITS-1:0]       iss_wa,
  input  logic                     regwrite,
  input  logic [REGBITS-1:0]       wa,
  input  logic [WIDTH-1:0]         wd,
  output logic [REGBITS:0]         pend_cnt,
  output logic                     idle
);
  localparam int DEPTH = 1 << REGBITS;
  logic [WIDTH-1:0]   mem_q [1:DEPTH-1];
  logic [DEPTH-1:0]   pend_q, pend_d;
  logic [REGBITS:0]   cnt_q, cnt_d;
  logic               clr, set, inc, dec;
  assign clr = regwrite && (wa != REGBITS'(REG_ZERO));
  assign set = iss_valid && (iss_wa != REGBITS'(REG_ZERO));
  // clear from writeback first, then set from issue so a same-cycle reissue stays pending
  always_comb begin
    pend_d = pend_q;
    if (clr) pend_d[wa] = 1'b0;
    if (set) pend_d[iss_wa] = 1'b1;
    pend_d[0] = 1'b0;
    inc   = set && !pend_q[iss_wa];
    dec   = clr && pend_q[wa] && !(set && iss_wa == wa);
    cnt_d = cnt_q + (REGBITS+1)'(inc) - (REGBITS+1)'(dec);
  end
  // scoreboard and pending counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end
  // register storage; register 0 is not stored and writes to it are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (clr) begin
      mem_q[wa] <= wd;
    end
  end
  assign pend_cnt = cnt_q;
  assign idle     = cnt_q == '0;
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [REGBITS-1:0] ra_w;
    logic [WIDTH-1:0]   ram_rd;
    assign ra_w   = ra[i*REGBITS +: REGBITS];
    assign ram_rd = (ra_w == REGBITS'(REG_ZERO)) ? '0 : mem_q[ra_w];
    regfile_rdport #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_rdport (
      .ra_i       (ra_w),
      .ram_rd_i   (ram_rd),
      .pend_i     (pend_q[ra_w]),
      .regwrite_i (regwrite),
      .wa_i       (wa),
      .wd_i       (wd),
      .rd_o       (rd[i*WIDTH +: WIDTH]),
      .rbusy_o    (rbusy[i])
    );
  end
endmodule
